// File: rtl/rd_capture.sv
// rd_capture: SDRAM read-data capture sequencer feeding a small show-ahead FIFO.
// After a read command the block waits for the CAS latency to expire, then
// samples dq_in on every cycle of the burst and pushes each beat into the FIFO.
// The host drains the FIFO with a valid/ready handshake.
// Optional feature: define RD_OVF_FLAG_EN to add a sticky overflow flag
// (rd_ovf) and its clear input (ovf_clr). Without it, beats that arrive
// while the FIFO is full are dropped silently.
module rd_capture #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              rd_start,
    input  logic [1:0]        burst_len,
    input  logic              cslt_end,
    input  logic [DATA_W-1:0] dq_in,
    output logic              rd_busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready
`ifdef RD_OVF_FLAG_EN
    ,
    input  logic              ovf_clr,
    output logic              rd_ovf
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        beatsLeft_q, beatsLeft_d;
    logic [3:0]        decodedLen;
    logic              capture;
    logic              lastBeat;

    logic [DATA_W-1:0] fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0]     wrPtr_q, wrPtr_d;
    logic [AW-1:0]     rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              fifoFull;
    logic              pop;
    logic              pushAccept;

    // Burst code to beat count, and the per-cycle capture decision.
    // WAIT only looks at cslt_end once it is actually in WAIT, so a level
    // that was already high while idle never captures in the rd_start cycle.
    always_comb begin
        decodedLen = 4'd8;
        case (burst_len)
            2'b00:   decodedLen = 4'd1;
            2'b01:   decodedLen = 4'd2;
            2'b10:   decodedLen = 4'd4;
            default: decodedLen = 4'd8;
        endcase
        capture  = ((state_q == WAIT) && cslt_end) || (state_q == BURST);
        lastBeat = capture && (beatsLeft_q == 4'd1);
    end

    // Sequencer state and remaining-beat counter.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            beatsLeft_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            beatsLeft_q <= beatsLeft_d;
        end
    end

    // Next-state logic; rd_start is only honoured in IDLE or on the final beat.
    always_comb begin
        state_d     = state_q;
        beatsLeft_d = beatsLeft_q;
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    state_d     = WAIT;
                    beatsLeft_d = decodedLen;
                end
            end
            WAIT, BURST: begin
                if (capture) begin
                    beatsLeft_d = beatsLeft_q - 4'd1;
                    if (lastBeat) begin
                        if (rd_start) begin
                            state_d     = WAIT;
                            beatsLeft_d = decodedLen;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                beatsLeft_d = 4'd0;
            end
        endcase
    end

    // FIFO control: a beat is kept unless the FIFO is full with no pop this cycle.
    always_comb begin
        fifoFull   = (count_q == CW'(FIFO_DEPTH));
        rd_valid   = (count_q != '0);
        pop        = rd_valid && rd_ready;
        pushAccept = capture && (!fifoFull || pop);
        wrPtr_d    = pushAccept ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d    = pop ? rdPtr_q + AW'(1) : rdPtr_q;
        count_d    = count_q;
        case ({pushAccept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage, cleared on reset so the head word reads as zero.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_q[i] <= '0;
            end
        end else if (pushAccept) begin
            fifoMem_q[wrPtr_q] <= dq_in;
        end
    end

    assign rd_data = fifoMem_q[rdPtr_q];
    assign rd_busy = (state_q != IDLE);

`ifdef RD_OVF_FLAG_EN
    logic rdOvf_q;
    logic dropBeat;

    assign dropBeat = capture && fifoFull && !pop;

    // Sticky overflow flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rdOvf_q <= 1'b0;
        end else if (dropBeat) begin
            rdOvf_q <= 1'b1;
        end else if (ovf_clr) begin
            rdOvf_q <= 1'b0;
        end
    end

    assign rd_ovf = rdOvf_q;
`endif

endmodule

// File: tb/tb_rd_capture.sv
// tb_rd_capture: directed self-checking bench for rd_capture.
// Expected read words are queued as the bench drives captured beats and are
// compared whenever the host side pops a word. Overflow-flag checks are
// compiled only when RD_OVF_FLAG_EN is defined.
module tb_rd_capture;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              rd_start;
    logic [1:0]        burst_len;
    logic              cslt_end;
    logic [DATA_W-1:0] dq_in;
    logic              rd_busy;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
`ifdef RD_OVF_FLAG_EN
    logic              ovf_clr;
    logic              rd_ovf;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ [$];

    rd_capture #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .rd_start  (rd_start),
        .burst_len (burst_len),
        .cslt_end  (cslt_end),
        .dq_in     (dq_in),
        .rd_busy   (rd_busy),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready)
`ifdef RD_OVF_FLAG_EN
        ,
        .ovf_clr   (ovf_clr),
        .rd_ovf    (rd_ovf)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepClk;
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic [1:0] len, input logic cslt,
                                 input logic [31:0] dq, input logic ready, input logic pushExp);
        rd_start  = start;
        burst_len = len;
        cslt_end  = cslt;
        dq_in     = dq;
        rd_ready  = ready;
        if (pushExp) expQ.push_back(dq);
    endtask

    task automatic drainFifo(input string tag);
        int budget;
        budget   = 0;
        rd_start = 1'b0;
        rd_ready = 1'b1;
        while ((rd_valid || expQ.size() != 0) && budget < 40) begin
            stepClk;
            budget++;
        end
        checkOutput({tag, "_drainDone"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, "_queueEmpty"}, 32'(expQ.size()), 32'd0);
    endtask

    // Scoreboard: every host pop must match the oldest expected word.
    always @(negedge Clk) begin
        if (Reset && rd_valid && rd_ready) begin
            if (expQ.size() == 0) checkOutput("popWithEmptyQueue", 32'(expQ.size()), 32'd1);
            else                  checkOutput("popData", rd_data, expQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b0;
`ifdef RD_OVF_FLAG_EN
        ovf_clr = 1'b0;
`endif
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) stepClk;
        checkOutput("resetValid", 32'(rd_valid), 32'd0);
        checkOutput("resetBusy", 32'(rd_busy), 32'd0);
        checkOutput("resetData", rd_data, 32'd0);
`ifdef RD_OVF_FLAG_EN
        checkOutput("resetOvf", 32'(rd_ovf), 32'd0);
`endif
        Reset = 1'b1;
        stepClk;
        checkOutput("idleBusy", 32'(rd_busy), 32'd0);

        // 4-beat burst, CAS latency expires three cycles after rd_start.
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0); stepClk;
        checkOutput("t1BusyInWait", 32'(rd_busy), 32'd1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0); stepClk;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0); stepClk;
        checkOutput("t1NoEarlyCapture", 32'(rd_valid), 32'd0);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'd1, 1'b0, 1'b1); stepClk;
        checkOutput("t1FirstValid", 32'(rd_valid), 32'd1);
        checkOutput("t1FirstWord", rd_data, 32'd1);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'd2, 1'b0, 1'b1); stepClk;
        applyStimulus(1'b0, 2'b10, 1'b1, 32'd3, 1'b0, 1'b1); stepClk;
        checkOutput("t1BusyMidBurst", 32'(rd_busy), 32'd1);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'd4, 1'b0, 1'b1); stepClk;
        checkOutput("t1BusyLowAfterLast", 32'(rd_busy), 32'd0);
        checkOutput("t1HeadHeld", rd_data, 32'd1);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'd5, 1'b0, 1'b0); stepClk;
        drainFifo("t1");

        // Stale high cslt_end must not capture in the rd_start cycle.
        applyStimulus(1'b1, 2'b00, 1'b1, 32'hA0, 1'b0, 1'b0); stepClk;
        checkOutput("t2NoCaptureStartCycle", 32'(rd_valid), 32'd0);
        checkOutput("t2BusyInWait", 32'(rd_busy), 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'hB1, 1'b0, 1'b1); stepClk;
        checkOutput("t2OneWordValid", 32'(rd_valid), 32'd1);
        checkOutput("t2OneWordData", rd_data, 32'hB1);
        checkOutput("t2BusyDone", 32'(rd_busy), 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'hC2, 1'b0, 1'b0); stepClk;
        drainFifo("t2");

        // 8-beat burst into a 4-deep FIFO with no host reads: last 4 dropped.
        applyStimulus(1'b1, 2'b11, 1'b1, 32'h0, 1'b0, 1'b0); stepClk;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 2'b11, 1'b1, 32'h30 + 32'(i), 1'b0, (i <= 4));
`ifdef RD_OVF_FLAG_EN
            ovf_clr = (i == 6);
`endif
            stepClk;
`ifdef RD_OVF_FLAG_EN
            if (i == 4) checkOutput("t3OvfNotYet", 32'(rd_ovf), 32'd0);
            if (i >= 5) checkOutput("t3OvfSet", 32'(rd_ovf), 32'd1);
`endif
        end
        checkOutput("t3BusyDone", 32'(rd_busy), 32'd0);
        checkOutput("t3HeadKept", rd_data, 32'h31);
`ifdef RD_OVF_FLAG_EN
        ovf_clr = 1'b1;
        stepClk;
        ovf_clr = 1'b0;
        checkOutput("t3OvfCleared", 32'(rd_ovf), 32'd0);
`endif
        drainFifo("t3");

        // Fill the FIFO, then stream 8 beats while the host pops every cycle.
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h0, 1'b0, 1'b0); stepClk;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 2'b10, 1'b1, 32'h40 + 32'(i), 1'b0, 1'b1); stepClk;
        end
        checkOutput("t4FullValid", 32'(rd_valid), 32'd1);
        applyStimulus(1'b1, 2'b11, 1'b1, 32'h0, 1'b0, 1'b0); stepClk;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 2'b11, 1'b1, 32'h50 + 32'(i), 1'b1, 1'b1); stepClk;
            checkOutput("t4ValidAtFull", 32'(rd_valid), 32'd1);
`ifdef RD_OVF_FLAG_EN
            checkOutput("t4NoOvf", 32'(rd_ovf), 32'd0);
`endif
        end
        drainFifo("t4");

        // Back-to-back: rd_start on the last beat of a 2-beat burst.
        applyStimulus(1'b1, 2'b01, 1'b1, 32'h0, 1'b1, 1'b0); stepClk;
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h61, 1'b1, 1'b1); stepClk;
        checkOutput("t5BusyBurst", 32'(rd_busy), 32'd1);
        applyStimulus(1'b1, 2'b00, 1'b1, 32'h62, 1'b1, 1'b1); stepClk;
        checkOutput("t5BackToBackWait", 32'(rd_busy), 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h6F, 1'b1, 1'b0); stepClk;
        checkOutput("t5StillWaiting", 32'(rd_busy), 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h63, 1'b1, 1'b1); stepClk;
        checkOutput("t5SecondDone", 32'(rd_busy), 32'd0);
        drainFifo("t5a");

        // rd_start during non-final beats must be ignored.
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h0, 1'b1, 1'b0); stepClk;
        applyStimulus(1'b1, 2'b11, 1'b1, 32'h71, 1'b1, 1'b1); stepClk;
        applyStimulus(1'b1, 2'b11, 1'b1, 32'h72, 1'b1, 1'b1); stepClk;
        applyStimulus(1'b0, 2'b11, 1'b1, 32'h73, 1'b1, 1'b1); stepClk;
        applyStimulus(1'b0, 2'b11, 1'b1, 32'h74, 1'b1, 1'b1); stepClk;
        checkOutput("t5MidStartIgnored", 32'(rd_busy), 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h75, 1'b1, 1'b0); stepClk;
        checkOutput("t5StaysIdle", 32'(rd_busy), 32'd0);
        drainFifo("t5b");

        // Reset in the middle of a 4-beat burst.
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h0, 1'b0, 1'b0); stepClk;
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h81, 1'b0, 1'b1); stepClk;
        checkOutput("t6FirstBeatValid", 32'(rd_valid), 32'd1);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h82, 1'b0, 1'b0);
        Reset = 1'b0;
        #1;
        checkOutput("t6ResetValid", 32'(rd_valid), 32'd0);
        checkOutput("t6ResetBusy", 32'(rd_busy), 32'd0);
        checkOutput("t6ResetData", rd_data, 32'd0);
        expQ.delete();
        stepClk;
        stepClk;
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'b10, 1'b1, 32'h90 + 32'(i), 1'b0, 1'b0); stepClk;
            checkOutput("t6NoWriteAfterRelease", 32'(rd_valid), 32'd0);
            checkOutput("t6IdleAfterRelease", 32'(rd_busy), 32'd0);
        end
        drainFifo("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
